// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the spacing, in clk cycles, between successive
// rising edges of an asynchronous pulse train. Results are offered on a
// valid/ready handshake. meas_lost records any result that was overwritten
// before the consumer took it.
module tick_period_meter #(
  parameter int W     = 16,
  parameter int MIN_W = 2
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         sig_in,
  input  logic         enable,
  input  logic         meas_ready,
  output logic         meas_valid,
  output logic [W-1:0] meas_period,
  output logic         meas_ovf,
  output logic         meas_lost,
  output logic         busy
);

  generate
    if (W < MIN_W) begin : g_bad_width
      $error("tick_period_meter: W=%0d is below MIN_W=%0d", W, MIN_W);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  // Input capture chain. The detected edge is registered once more so that a
  // capture lands three clk edges after the edge that first samples sig_in
  // high. The delay is the same for every edge, so the measured spacing is
  // not affected.
  logic sync1_reg;
  logic sync2_reg;
  logic hist_reg;
  logic edge_reg;
  logic rise_det;

  assign rise_det = sync2_reg & ~hist_reg;

  // Two-flop synchronizer, history flop and the registered edge pulse
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      sync1_reg <= sig_in;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
      edge_reg  <= rise_det;
    end
  end

  state_t       state_reg;
  logic [W-1:0] cnt_reg;
  logic         sat_reg;
  logic         valid_reg;
  logic [W-1:0] period_reg;
  logic         ovf_reg;
  logic         lost_reg;
  logic         busy_reg;

  // Measurement FSM together with the result register and handshake
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      sat_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      period_reg <= '0;
      ovf_reg    <= 1'b0;
      lost_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      // An acceptance drops valid. A capture later in this block overrides it.
      if (valid_reg && meas_ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            state_reg <= S_ARM;
            busy_reg  <= 1'b1;
            lost_reg  <= 1'b0;
          end
        end

        S_ARM: begin
          if (!enable) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
          end else if (edge_reg) begin
            // First edge only starts the count. There is no earlier edge to measure from.
            state_reg <= S_COUNT;
            cnt_reg   <= CNT_ONE;
            sat_reg   <= 1'b0;
          end
        end

        S_COUNT: begin
          if (!enable) begin
            // Leaving mid-count discards the partial period. Any pending result stays.
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
          end else if (edge_reg) begin
            period_reg <= cnt_reg;
            ovf_reg    <= sat_reg;
            valid_reg  <= 1'b1;
            // Overwriting a result nobody took is a loss. A same-edge acceptance is not.
            if (valid_reg && !meas_ready) begin
              lost_reg <= 1'b1;
            end
            cnt_reg <= CNT_ONE;
            sat_reg <= 1'b0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == (CNT_MAX - 1'b1)) begin
              sat_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
          sat_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign meas_valid  = valid_reg;
  assign meas_period = period_reg;
  assign meas_ovf    = ovf_reg;
  assign meas_lost   = lost_reg;
  assign busy        = busy_reg;

endmodule
